// File: rtl/move_pkg.sv
// Shared FSM encoding and move-record layout for the move queue.
// MOVE_HALT_EN adds a synchronous halt/flush input to the scheduler.
package move_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DIR_W   = 1;
    localparam int FIELD_W = 64;

    // Stored record: {dir, duration, increment, incinc}
    function automatic int rec_w(input int w);
        return DIR_W + 3 * w;
    endfunction

endpackage

// File: rtl/move_queue_mem.sv
// Move entry storage: one write port, one asynchronous read port.
// Entries are not reset; validity is tracked by the scheduler level.
module move_queue_mem
    import move_pkg::*;
#(
    parameter int DEPTH_BITS = 2,
    parameter int W          = FIELD_W
)(
    input  logic                  CLK,
    input  logic                  i_we,
    input  logic [DEPTH_BITS-1:0] i_waddr,
    input  logic [rec_w(W)-1:0]   i_wdata,
    input  logic [DEPTH_BITS-1:0] i_raddr,
    output logic [rec_w(W)-1:0]   o_rdata
);

    logic [rec_w(W)-1:0] r_mem [2**DEPTH_BITS];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/move_queue_scheduler.sv
// Circular move queue feeding a DDA timer via IDLE/LOAD/RUN handshake.
// Optional macro MOVE_HALT_EN adds input halt (synchronous flush).
module move_queue_scheduler
    import move_pkg::*;
#(
    parameter int DEPTH_BITS = 2,
    parameter int W          = FIELD_W
)(
    input  logic                CLK,
    input  logic                resetn,
`ifdef MOVE_HALT_EN
    input  logic                halt,
`endif
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic                wr_dir,
    input  logic [W-1:0]        wr_duration,
    input  logic [W-1:0]        wr_increment,
    input  logic [W-1:0]        wr_incinc,
    output logic                dda_start,
    input  logic                dda_done,
    output logic                cur_dir,
    output logic [W-1:0]        cur_duration,
    output logic [W-1:0]        cur_increment,
    output logic [W-1:0]        cur_incinc,
    output logic                move_active,
    output logic [DEPTH_BITS:0] level,
    output logic                buffer_dtr
);

    localparam int REC_W = rec_w(W);
    localparam logic [DEPTH_BITS:0] LV_ONE   = (DEPTH_BITS+1)'(1);
    localparam logic [DEPTH_BITS:0] LV_DEPTH = (DEPTH_BITS+1)'(2**DEPTH_BITS);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_level;
    logic [DEPTH_BITS:0]   w_level_nxt;
    logic                  w_halt;
    logic                  w_push;
    logic                  w_pop;
    logic [REC_W-1:0]      w_wdata;
    logic [REC_W-1:0]      w_rdata;

`ifdef MOVE_HALT_EN
    assign w_halt = halt;
`else
    assign w_halt = 1'b0;
`endif

    assign buffer_dtr  = r_level < LV_DEPTH;
    assign wr_ready    = buffer_dtr & ~w_halt;
    assign w_push      = wr_valid & wr_ready;
    assign w_pop       = (r_state == ST_RUN) & dda_done;
    assign dda_start   = r_state == ST_LOAD;
    assign move_active = r_state != ST_IDLE;
    assign level       = r_level;

    assign w_wdata = {wr_dir, wr_duration, wr_increment, wr_incinc};
    assign {cur_dir, cur_duration, cur_increment, cur_incinc} = w_rdata;

    move_queue_mem #(
        .DEPTH_BITS(DEPTH_BITS),
        .W         (W)
    ) u_mem (
        .CLK    (CLK),
        .i_we   (w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(w_wdata),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_rdata)
    );

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + LV_ONE;
            2'b01:   w_level_nxt = r_level - LV_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // A pop that coincides with a write keeps the next move ready: no idle gap
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (r_level != '0) w_state_nxt = ST_LOAD;
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_pop) begin
                    w_state_nxt = (w_level_nxt != '0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_halt) begin
            r_state  <= ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_move_queue_scheduler.sv
// Self-checking bench for move_queue_scheduler against a queue-based model.
// Define MOVE_HALT_EN to also exercise the halt/flush input.
module tb_move_queue_scheduler;

    localparam int DB    = 2;
    localparam int W     = 64;
    localparam int DEPTH = 4;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;

    typedef struct packed {
        logic         dir;
        logic [W-1:0] dur;
        logic [W-1:0] inc;
        logic [W-1:0] ii;
    } mv_t;

    logic          CLK = 1'b0;
    logic          resetn = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_dir = 1'b0;
    logic [W-1:0]  wr_duration = '0;
    logic [W-1:0]  wr_increment = '0;
    logic [W-1:0]  wr_incinc = '0;
    logic          dda_done = 1'b0;
`ifdef MOVE_HALT_EN
    logic          r_halt = 1'b0;
`endif
    logic          wr_ready;
    logic          dda_start;
    logic          cur_dir;
    logic [W-1:0]  cur_duration;
    logic [W-1:0]  cur_increment;
    logic [W-1:0]  cur_incinc;
    logic          move_active;
    logic [DB:0]   level;
    logic          buffer_dtr;

    int checks = 0;
    int failures = 0;

    mv_t mq[$];
    int  ph = P_IDLE;

    move_queue_scheduler #(.DEPTH_BITS(DB), .W(W)) dut (
        .CLK          (CLK),
        .resetn       (resetn),
`ifdef MOVE_HALT_EN
        .halt         (r_halt),
`endif
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_dir       (wr_dir),
        .wr_duration  (wr_duration),
        .wr_increment (wr_increment),
        .wr_incinc    (wr_incinc),
        .dda_start    (dda_start),
        .dda_done     (dda_done),
        .cur_dir      (cur_dir),
        .cur_duration (cur_duration),
        .cur_increment(cur_increment),
        .cur_incinc   (cur_incinc),
        .move_active  (move_active),
        .level        (level),
        .buffer_dtr   (buffer_dtr)
    );

    always #5 CLK = ~CLK;

    wire [DB+3:0] w_stat = {level, dda_start, move_active, buffer_dtr};
    wire mv_t     w_head = {cur_dir, cur_duration, cur_increment, cur_incinc};

    function automatic mv_t mk(input logic d, input logic [W-1:0] du,
                               input logic [W-1:0] in, input logic [W-1:0] ii);
        mv_t m;
        m.dir = d; m.dur = du; m.inc = in; m.ii = ii;
        return m;
    endfunction

    function automatic logic [DB+3:0] exp_stat();
        return {(DB+1)'(mq.size()), ph == P_LOAD, ph != P_IDLE, mq.size() < DEPTH};
    endfunction

    // Drive one cycle, let the edge happen, advance the model, settle 1ns.
    task automatic cycle(input logic v, input mv_t m, input logic done, input logic h);
        bit acc;
        bit pop;
        int old;
        wr_valid = v;
        {wr_dir, wr_duration, wr_increment, wr_incinc} = m;
        dda_done = done;
`ifdef MOVE_HALT_EN
        r_halt = h;
`endif
        @(posedge CLK);
        old = mq.size();
        acc = v && !h && (old < DEPTH);
        pop = (ph == P_RUN) && done;
        if (h) begin
            mq.delete();
            ph = P_IDLE;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(m);
            case (ph)
                P_IDLE:  if (old != 0) ph = P_LOAD;
                P_LOAD:  ph = P_RUN;
                default: if (pop) ph = (mq.size() != 0) ? P_LOAD : P_IDLE;
            endcase
        end
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++;
        if (w_stat !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_stat got=%b exp=%b", w_stat, {3'd0, 3'b001});
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
        end
        @(negedge CLK);
        resetn = 1'b1;
    endtask

    task automatic test_single();
        cycle(1'b1, mk(1, 100, 5, 0), 1'b0, 1'b0);
        checks++;
        if (w_stat !== {3'd1, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL single_accept got=%b exp=%b", w_stat, {3'd1, 3'b001});
        end
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        checks++;
        if (w_stat !== {3'd1, 1'b1, 1'b1, 1'b1} || cur_duration !== 64'd100
            || cur_dir !== 1'b1 || cur_increment !== 64'd5 || cur_incinc !== 64'd0) begin
            failures++;
            $display("FAIL single_start stat=%b dur=%0d dir=%b exp stat=%b dur=100 dir=1",
                     w_stat, cur_duration, cur_dir, {3'd1, 3'b111});
        end
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        checks++;
        if (w_stat !== {3'd1, 1'b0, 1'b1, 1'b1} || cur_duration !== 64'd100) begin
            failures++;
            $display("FAIL single_run stat=%b dur=%0d exp stat=%b dur=100",
                     w_stat, cur_duration, {3'd1, 3'b011});
        end
        cycle(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
        checks++;
        if (w_stat !== {3'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL single_done got=%b exp=%b", w_stat, {3'd0, 3'b001});
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(0, 64'(11 + i), 1, 2), 1'b0, 1'b0);
        checks++;
        if (level !== 3'd4 || buffer_dtr !== 1'b0 || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_level level=%0d dtr=%b rdy=%b exp level=4 dtr=0 rdy=0",
                     level, buffer_dtr, wr_ready);
        end
        cycle(1'b1, mk(1, 99, 9, 9), 1'b0, 1'b0);
        checks++;
        if (level !== 3'd4 || w_stat !== exp_stat()) begin
            failures++;
            $display("FAIL full_ignore got=%b exp=%b", w_stat, exp_stat());
        end
        cycle(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
        checks++;
        if (level !== 3'd3 || dda_start !== 1'b1 || cur_duration !== 64'd12) begin
            failures++;
            $display("FAIL full_pop level=%0d start=%b dur=%0d exp level=3 start=1 dur=12",
                     level, dda_start, cur_duration);
        end
        drain(10);
        checks++;
        if (w_stat !== {3'd0, 3'b001}) begin
            failures++;
            $display("FAIL full_drain got=%b exp=%b", w_stat, {3'd0, 3'b001});
        end
    endtask

    task automatic test_simul();
        cycle(1'b1, mk(0, 20, 0, 0), 1'b0, 1'b0);
        drain(4);
        cycle(1'b1, mk(0, 21, 0, 0), 1'b0, 1'b0);
        cycle(1'b1, mk(1, 22, 0, 0), 1'b0, 1'b0);
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        checks++;
        if (w_stat !== {3'd2, 1'b0, 1'b1, 1'b1} || cur_duration !== 64'd21) begin
            failures++;
            $display("FAIL simul_pre stat=%b dur=%0d exp stat=%b dur=21",
                     w_stat, cur_duration, {3'd2, 3'b011});
        end
        cycle(1'b1, mk(0, 23, 7, 8), 1'b1, 1'b0);
        checks++;
        if (level !== 3'd2 || dda_start !== 1'b1 || cur_duration !== 64'd22) begin
            failures++;
            $display("FAIL simul_swap level=%0d start=%b dur=%0d exp level=2 start=1 dur=22",
                     level, dda_start, cur_duration);
        end
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        cycle(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
        checks++;
        if (w_head !== mk(0, 23, 7, 8) || dda_start !== 1'b1 || level !== 3'd1) begin
            failures++;
            $display("FAIL simul_wrapped dur=%0d start=%b level=%0d exp dur=23 start=1 level=1",
                     cur_duration, dda_start, level);
        end
        drain(4);
    endtask

    task automatic test_wrap();
        int idx = 0;
        int started = 0;
        bit ord_ok = 1'b1;
        for (int c = 0; c < 100; c++) begin
            bit v = idx < 6;
            bit acc = v && (mq.size() < DEPTH);
            cycle(v, mk(0, 64'(31 + idx), 0, 0), 1'b1, 1'b0);
            if (acc) idx++;
            if (dda_start === 1'b1) begin
                if (cur_duration !== 64'(31 + started)) ord_ok = 1'b0;
                started++;
            end
            if (idx == 6 && mq.size() == 0 && ph == P_IDLE) break;
        end
        checks++;
        if (!ord_ok || started != 6) begin
            failures++;
            $display("FAIL wrap_order ok=%0d started=%0d exp ok=1 started=6", ord_ok, started);
        end
        checks++;
        if (level !== 3'd0 || move_active !== 1'b0) begin
            failures++;
            $display("FAIL wrap_end level=%0d active=%b exp level=0 active=0", level, move_active);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            mv_t m = mk(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                        {$urandom, $urandom});
            cycle(1'($urandom_range(0, 1)), m, $urandom_range(0, 2) == 0, 1'b0);
            checks++;
            if (w_stat !== exp_stat() || wr_ready !== (mq.size() < DEPTH)) begin
                failures++;
                if (bad++ < 5)
                    $display("FAIL rand_stat cyc=%0d got=%b rdy=%b exp=%b", c, w_stat,
                             wr_ready, exp_stat());
            end
            if (mq.size() > 0) begin
                checks++;
                if (w_head !== mq[0]) begin
                    failures++;
                    if (bad++ < 5)
                        $display("FAIL rand_head cyc=%0d dur=%0h exp=%0h", c, cur_duration,
                                 mq[0].dur);
                end
            end
        end
        drain(10);
    endtask

`ifdef MOVE_HALT_EN
    task automatic test_halt();
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(0, 64'(40 + i), 0, 0), 1'b0, 1'b0);
        checks++;
        if (level !== 3'd3 || move_active !== 1'b1 || dda_start !== 1'b0) begin
            failures++;
            $display("FAIL halt_pre level=%0d active=%b exp level=3 active=1", level, move_active);
        end
        cycle(1'b1, mk(0, 50, 0, 0), 1'b1, 1'b1);
        checks++;
        if (w_stat !== {3'd0, 3'b001} || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_flush stat=%b rdy=%b exp stat=%b rdy=0", w_stat, wr_ready,
                     {3'd0, 3'b001});
        end
        cycle(1'b1, mk(0, 51, 0, 0), 1'b0, 1'b1);
        checks++;
        if (w_stat !== {3'd0, 3'b001} || wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_hold stat=%b rdy=%b exp stat=%b rdy=0", w_stat, wr_ready,
                     {3'd0, 3'b001});
        end
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        checks++;
        if (w_stat !== {3'd0, 3'b001} || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL halt_release stat=%b rdy=%b exp stat=%b rdy=1", w_stat, wr_ready,
                     {3'd0, 3'b001});
        end
    endtask
`endif

    task automatic test_reset_mid();
        int spurious = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(1, 64'(60 + i), 0, 0), 1'b0, 1'b0);
        cycle(1'b0, mk(0, 0, 0, 0), 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        checks++;
        if (w_stat !== {3'd0, 3'b001} || wr_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid stat=%b rdy=%b exp stat=%b rdy=1", w_stat, wr_ready,
                     {3'd0, 3'b001});
        end
        mq.delete();
        ph = P_IDLE;
        @(negedge CLK);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, mk(0, 0, 0, 0), 1'b1, 1'b0);
            if (dda_start !== 1'b0 || level !== 3'd0 || move_active !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL rst_spurious bad_cycles=%0d exp=0", spurious);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_simul();
        test_wrap();
        test_random();
`ifdef MOVE_HALT_EN
        test_halt();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_queue_scheduler.md
MOVE_QUEUE_SCHEDULER -- requirements
Module: move_queue_scheduler

Interface
REQ-001 Parameter DEPTH_BITS, default 2, log2 of queue depth (depth = 2**DEPTH_BITS entries).
REQ-002 Parameter W, default 64, width of duration/increment/incrementincrement fields.
REQ-003 CLK  input  1  single system clock, all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 wr_valid  input  1  SPI command decoder offers a complete move.
REQ-006 wr_ready  output  1  queue can accept; move written when wr_valid & wr_ready at a rising edge.
REQ-007 wr_dir / wr_duration / wr_increment / wr_incinc  input  1/W/W/W  move fields.
REQ-008 dda_start  output  1  one-cycle pulse telling the DDA timer to begin the head move.
REQ-009 dda_done  input  1  one-cycle pulse from the DDA timer: current move finished.
REQ-010 cur_dir / cur_duration / cur_increment / cur_incinc  output  1/W/W/W  head-entry fields driven to the DDA timer.
REQ-011 move_active  output  1  high whenever state is not IDLE.
REQ-012 level  output  DEPTH_BITS+1  occupied entries, including the executing move.
REQ-013 buffer_dtr  output  1  high when level < depth (host flow control).

Function
REQ-014 Storage SHALL be a circular buffer with wr_ptr, rd_ptr (DEPTH_BITS bits, wrap modulo depth) and a separate level counter.
REQ-015 wr_ready SHALL equal buffer_dtr; a write while full SHALL be ignored with no state change.
REQ-016 FSM states SHALL be IDLE, LOAD, RUN.
REQ-017 IDLE -> LOAD at the first edge where level != 0.
REQ-018 dda_start SHALL be high exactly during the single cycle spent in LOAD; LOAD -> RUN unconditionally at the next edge.
REQ-019 In RUN, dda_done SHALL pop the head (rd_ptr+1, level-1) at that edge; next state LOAD if level after pop is nonzero, else IDLE.
REQ-020 dda_done in IDLE or LOAD SHALL be ignored.
REQ-021 Simultaneous accepted write and pop SHALL leave level unchanged and advance both pointers.
REQ-022 cur_* outputs SHALL reflect entry[rd_ptr] and remain stable from LOAD through RUN until the pop.
REQ-023 Latency: a write accepted at edge N into an empty IDLE queue yields dda_start high in the cycle after edge N+1.
REQ-024 Back-to-back: dda_done at edge M with further entries yields dda_start in the cycle after edge M (no idle cycle).

Reset
REQ-025 Asserting resetn low SHALL immediately force IDLE, pointers 0, level 0, dda_start 0, move_active 0, buffer_dtr 1; stored entries need not clear.
REQ-026 Reset mid-RUN SHALL discard all queued moves; no dda_start until a new write after release.

Configuration
REQ-027 Macro MOVE_HALT_EN SHALL add input halt (1 bit, active-high, synchronous to CLK).
REQ-028 With MOVE_HALT_EN: halt high at an edge SHALL force IDLE, pointers 0, level 0 (flush), and wr_ready SHALL be 0 while halt is high; halt overrides a simultaneous write or dda_done.
REQ-029 Without MOVE_HALT_EN: no halt port; queue is cleared only by reset.

Structure
REQ-030 Shared package move_pkg SHALL hold the FSM state encoding (IDLE=0, LOAD=1, RUN=2) and the move-record field widths.
REQ-031 One sub-module move_queue_mem SHALL hold the entry array (1 write port, 1 asynchronous read port); pointer/level/FSM logic stays in move_queue_scheduler.

Verification
REQ-032 Reset, then one write (duration=100, increment=5, incinc=0, dir=1) -> dda_start one cycle, cur_duration=100, cur_dir=1, level=1, move_active=1.
REQ-033 Four writes with no dda_done (DEPTH_BITS=2) -> level=4, buffer_dtr=0; fifth write ignored; after dda_done level=3 and the 2nd move is presented with dda_start.
REQ-034 Write and dda_done on the same edge with level=2 -> level stays 2, next move started, the written entry lands at the wrapped wr_ptr.
REQ-035 Run 6 moves through the queue (pointer wrap) -> cur_duration sequence matches write order exactly; IDLE and level=0 at end.
REQ-036 MOVE_HALT_EN: halt during RUN with level=3 -> next cycle IDLE, level=0, buffer_dtr=1; wr_ready low while halt held; no dda_start.
REQ-037 resetn low mid-RUN -> outputs at reset values without waiting for CLK; spurious dda_done after release -> ignored.
